// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use, taken-branch and data-memory wait handling.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_branch_taken,
  input  logic       mem_read_m,
  input  logic       mem_write_m,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             halted_r;

  logic mem_access_s;
  logic mem_stall_s;
  logic lu_s;
  logic branch_flush_s;

  // hazard detection from the current inputs and registered state
  always_comb begin
    mem_access_s = mem_read_m | mem_write_m;
    mem_stall_s  = mem_access_s & ~dmem_ready & (state_r != HALT);
    lu_s         = ex_mem_read & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  // output priority: halt, reset, memory freeze, load-use bubble, branch flush, normal advance
  always_comb begin
    dmem_req       = 1'b0;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;
    idex_en        = 1'b0;
    idex_flush     = 1'b0;
    exmem_en       = 1'b0;
    memwb_en       = 1'b0;
    branch_flush_s = 1'b0;
    if (state_r == HALT) begin
      dmem_req = 1'b0;
    end else if (rst) begin
      // every pipeline register loads a bubble while the PC holds
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      dmem_req = mem_access_s;
      if (mem_stall_s) begin
        pc_en = 1'b0;
      end else if (lu_s) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (id_branch_taken) begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        branch_flush_s = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // memory-wait FSM with timeout counter and sticky halt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      cnt_r    <= '0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_stall_s) begin
            state_r <= MEM_WAIT;
            cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= RUN;
            cnt_r   <= '0;
          end
        end
        MEM_WAIT: begin
          // a dropped request counts as completion since MEM is frozen here
          if (!mem_stall_s) begin
            state_r <= RUN;
            cnt_r   <= '0;
          end else if (cnt_r == TIMEOUT_C) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HALT: begin
          state_r  <= HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign halted = halted_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // saturating stall and branch-flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if ((mem_stall_s | lu_s) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;
`else
  // no performance counters in this build
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven directed bench for pipe_hazard_ctrl, plus hand-written timeout and perf-counter sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, id_branch_taken;
  logic       mem_read_m, mem_write_m, dmem_ready;
  logic       dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, memwb_en, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted}
  localparam logic [8:0] RSTV  = 9'b0_0_1_1_1_1_1_1_0;
  localparam logic [8:0] NORM  = 9'b0_1_1_0_1_0_1_1_0;
  localparam logic [8:0] NORMQ = 9'b1_1_1_0_1_0_1_1_0;
  localparam logic [8:0] LU    = 9'b0_0_0_0_1_1_1_1_0;
  localparam logic [8:0] LUQ   = 9'b1_0_0_0_1_1_1_1_0;
  localparam logic [8:0] BR    = 9'b0_1_1_1_1_0_1_1_0;
  localparam logic [8:0] FRZ   = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] HLT   = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       exmr;
    logic [4:0] ex_rt;
    logic       br;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic u, logic exmr,
                              logic [4:0] ert, logic br, logic mr, logic mw, logic rdy,
                              logic [8:0] exp);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = u; v.exmr = exmr; v.ex_rt = ert;
    v.br = br; v.mr = mr; v.mw = mw; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
    ex_mem_read = v.exmr; ex_rt = v.ex_rt; id_branch_taken = v.br;
    mem_read_m = v.mr; mem_write_m = v.mw; dmem_ready = v.rdy;
  endtask

  task automatic check(input string name, input int idx, input logic [8:0] exp);
    logic [8:0] act;
    act = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", name, idx, act, exp);
    end
  endtask

  // drive a vector mid-cycle, check before the next rising edge, then clock it in
  task automatic step(input string name, input int idx, input vec_t v);
    drive(v);
    #2;
    check(name, idx, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst rs rt u exmr ert br mr mw rdy exp
    tbl[0]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV);
    tbl[1]  = mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    tbl[2]  = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, LU);
    tbl[3]  = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, NORMQ);
    tbl[4]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    tbl[5]  = mk(1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, LU);
    tbl[6]  = mk(1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    tbl[7]  = mk(1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, BR);
    tbl[8]  = mk(1'b0, 5'd8, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    tbl[9]  = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[10] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[11] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[12] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, NORMQ);
    tbl[13] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    tbl[14] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORMQ);
    tbl[15] = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, FRZ);
    tbl[16] = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[17] = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[18] = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, LUQ);
    tbl[19] = mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, BR);
    tbl[20] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[21] = mk(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, RSTV);
    tbl[22] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    tbl[23] = mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, NORMQ);

    // settle reset before the first checked vector
    drive(tbl[0]);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      step("vec", i, tbl[i]);
    end

    // timeout: 5 frozen cycles, then sticky halt with everything off
    for (int i = 0; i < 5; i++) begin
      step("tmo_wait", i, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ));
    end
    step("halt", 0, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, HLT));
    step("halt", 1, mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, HLT));
    step("halt_rst", 0, mk(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HLT));
    step("post_rst", 0, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM));
    step("post_rst", 1, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ));
    step("post_rst", 2, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, NORMQ));

`ifdef PIPE_CTRL_PERF_EN
    step("perf_rst", 0, mk(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV));
    total++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      bad++;
      $display("FAIL perf_clear got=%0d/%0d want=0/0", stall_cycles, flush_count);
    end
    step("perf", 0, mk(1'b0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, LU));
    step("perf", 1, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM));
    step("perf", 2, mk(1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, LU));
    for (int i = 0; i < 3; i++) begin
      step("perf_w", i, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ));
    end
    step("perf", 3, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, NORMQ));
    step("perf", 4, mk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, BR));
    total++;
    if (stall_cycles !== 32'd5 || flush_count !== 32'd1) begin
      bad++;
      $display("FAIL perf_count got=%0d/%0d want=5/1", stall_cycles, flush_count);
    end
    step("perf_rst", 1, mk(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV));
    total++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      bad++;
      $display("FAIL perf_reclear got=%0d/%0d want=0/0", stall_cycles, flush_count);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
